// File: rtl/hack_sdram_pkg.sv
// hack_sdram_pkg -- shared definitions for the Hack <-> SDRAM master bridge.
//   state_t          : bridge FSM states
//   SDRAM_ADDR_W     : byte-address width of the Qsys masters (32)
//   sdram_byte_addr(): word address -> master byte address, modulo 2^32
package hack_sdram_pkg;

   localparam int SDRAM_ADDR_W = 32;

   typedef enum logic [3:0] {
      CLEAR,
      IDLE,
      W_LOAD,
      W_GO,
      W_BUSY,
      W_WAIT,
      R_GO,
      R_BUSY,
      R_WAIT,
      R_POP,
      R_DONE
   } state_t;

   // base + (word_addr << shift); the sum wraps in 32 bits by construction.
   function automatic logic [SDRAM_ADDR_W-1:0] sdram_byte_addr(
      input logic [SDRAM_ADDR_W-1:0] base,
      input logic [SDRAM_ADDR_W-1:0] word_addr,
      input int unsigned             shift
   );
      return base + (word_addr << shift);
   endfunction

endpackage

// File: rtl/hack_sdram_wfifo.sv
// hack_sdram_wfifo -- posted-write FIFO holding {address, data} pairs.
// Ports:
//   CLOCK_50, RESET_N        : clock, async active-low reset
//   push, push_addr/data     : enqueue (ignored when full)
//   pop                      : dequeue head (ignored when empty)
//   head_addr, head_data     : oldest entry
//   full, empty, count       : occupancy status
// DEPTH must be a power of two so the pointers wrap naturally.
module hack_sdram_wfifo #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 15,
   parameter int DATA_W = 16
) (
   input  logic                         CLOCK_50,
   input  logic                         RESET_N,
   input  logic                         push,
   input  logic [ADDR_W-1:0]            push_addr,
   input  logic [DATA_W-1:0]            push_data,
   input  logic                         pop,
   output logic [ADDR_W-1:0]            head_addr,
   output logic [DATA_W-1:0]            head_data,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   logic [ADDR_W-1:0] addr_mem [DEPTH];
   logic [DATA_W-1:0] data_mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic              do_push, do_pop;

   assign do_push   = push && !full;
   assign do_pop    = pop && !empty;
   assign full      = (count == CNT_W'(DEPTH));
   assign empty     = (count == '0);
   assign head_addr = addr_mem[rd_ptr];
   assign head_data = data_mem[rd_ptr];

   // NOTE: storage has no reset; only the pointers and count need one, and
   // an unreset array maps onto plain RAM/registers without a reset tree.
   always_ff @(posedge CLOCK_50) begin
      if (do_push) begin
         addr_mem[wr_ptr] <= push_addr;
         data_mem[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         // Simultaneous push and pop leave the count unchanged.
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/hack_sdram_bridge.sv
// hack_sdram_bridge -- Hack memory bus to Qsys SDRAM read/write masters.
// Writes are posted through a FIFO; reads are only accepted once every
// earlier write has reached the master, so a read always sees prior writes.
// Ports:
//   CLOCK_50, RESET_N                 : clock, async active-low reset
//   wr_en/wr_addr/wr_data, wr_full    : CPU posted-write port
//   rd_req/rd_addr, rd_ready          : CPU read request handshake
//   rd_valid, rd_data                 : read completion pulse and held data
//   boot_done                         : boot clear finished
//   write_*/read_* , *_buffer*        : Qsys master control and user buffers
// Build option: define HACK_SDRAM_BOOT_CLEAR_EN to zero words
// 0..CLEAR_WORDS-1 after every reset before reads are accepted.
module hack_sdram_bridge
   import hack_sdram_pkg::*;
#(
   parameter int          DATA_W      = 16,
   parameter int          ADDR_W      = 15,
   parameter logic [31:0] BASE_ADDR   = 32'h0,
   parameter int          FIFO_DEPTH  = 4,
   parameter int          CLEAR_WORDS = 2**ADDR_W
) (
   input  logic                    CLOCK_50,
   input  logic                    RESET_N,
   input  logic                    wr_en,
   input  logic [ADDR_W-1:0]       wr_addr,
   input  logic [DATA_W-1:0]       wr_data,
   output logic                    wr_full,
   input  logic                    rd_req,
   input  logic [ADDR_W-1:0]       rd_addr,
   output logic                    rd_ready,
   output logic                    rd_valid,
   output logic [DATA_W-1:0]       rd_data,
   output logic                    boot_done,
   output logic [SDRAM_ADDR_W-1:0] write_base,
   output logic [SDRAM_ADDR_W-1:0] read_base,
   output logic [SDRAM_ADDR_W-1:0] write_length,
   output logic [SDRAM_ADDR_W-1:0] read_length,
   output logic                    write_go,
   output logic                    read_go,
   input  logic                    write_done,
   input  logic                    read_done,
   output logic                    write_buffer,
   output logic [DATA_W-1:0]       write_buffer_data,
   input  logic                    write_buffer_full,
   output logic                    read_buffer,
   input  logic [DATA_W-1:0]       read_buffer_data,
   input  logic                    read_data_available
);

   localparam int unsigned BYTE_SHIFT = $clog2(DATA_W/8);
   localparam int          CNT_W      = $clog2(FIFO_DEPTH+1);

   state_t              state;
   logic                fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [CNT_W-1:0]    fifo_count;
   logic [ADDR_W-1:0]   head_addr;
   logic [DATA_W-1:0]   head_data;
   logic                clearing;
   logic [31:0]         load_addr;
   logic [DATA_W-1:0]   load_data;

   assign write_length = SDRAM_ADDR_W'(DATA_W/8);
   assign read_length  = SDRAM_ADDR_W'(DATA_W/8);

   assign wr_full   = fifo_full;
   assign fifo_push = wr_en && !fifo_full;
   assign fifo_pop  = (state == W_LOAD) && !write_buffer_full && !clearing;
   // A write pushed this cycle must be ordered before any read, so a
   // simultaneous read is refused.
   assign rd_ready  = (state == IDLE) && (fifo_count == '0) && boot_done && !fifo_push;

`ifdef HACK_SDRAM_BOOT_CLEAR_EN
   localparam int CLR_W = $clog2(CLEAR_WORDS+1);
   logic [CLR_W-1:0] clr_cnt;
   logic             boot_done_q;

   assign boot_done = boot_done_q;
   assign clearing  = !boot_done_q;
   assign load_addr = clearing ? 32'(clr_cnt) : 32'(head_addr);
   assign load_data = clearing ? '0 : head_data;
`else
   assign boot_done = 1'b1;
   assign clearing  = 1'b0;
   assign load_addr = 32'(head_addr);
   assign load_data = head_data;
`endif

   hack_sdram_wfifo #(
      .DEPTH  (FIFO_DEPTH),
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_wfifo (
      .CLOCK_50  (CLOCK_50),
      .RESET_N   (RESET_N),
      .push      (fifo_push),
      .push_addr (wr_addr),
      .push_data (wr_data),
      .pop       (fifo_pop),
      .head_addr (head_addr),
      .head_data (head_data),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
`ifdef HACK_SDRAM_BOOT_CLEAR_EN
         state       <= CLEAR;
         clr_cnt     <= '0;
         boot_done_q <= 1'b0;
`else
         state       <= IDLE;
`endif
         write_go          <= 1'b0;
         read_go           <= 1'b0;
         write_buffer      <= 1'b0;
         read_buffer       <= 1'b0;
         rd_valid          <= 1'b0;
         rd_data           <= '0;
         write_buffer_data <= '0;
         write_base        <= '0;
         read_base         <= '0;
      end else begin
         // NOTE: strobes default low every cycle, so a state that raises one
         // produces a registered pulse exactly one cycle long.
         write_go     <= 1'b0;
         read_go      <= 1'b0;
         write_buffer <= 1'b0;
         read_buffer  <= 1'b0;
         rd_valid     <= 1'b0;

         unique case (state)
            CLEAR: begin
`ifdef HACK_SDRAM_BOOT_CLEAR_EN
               if (clr_cnt == CLR_W'(CLEAR_WORDS)) begin
                  boot_done_q <= 1'b1;
                  state       <= IDLE;
               end else begin
                  state <= W_LOAD;
               end
`else
               state <= IDLE;
`endif
            end
            IDLE: begin
               if (!fifo_empty && write_done) begin
                  state <= W_LOAD;
               end else if (rd_req && rd_ready) begin
                  read_base <= sdram_byte_addr(BASE_ADDR, 32'(rd_addr), BYTE_SHIFT);
                  state     <= R_GO;
               end
            end
            W_LOAD: begin
               if (!write_buffer_full) begin
                  write_buffer      <= 1'b1;
                  write_buffer_data <= load_data;
                  write_base        <= sdram_byte_addr(BASE_ADDR, load_addr, BYTE_SHIFT);
                  state             <= W_GO;
               end
            end
            W_GO: begin
               write_go <= 1'b1;
               state    <= W_BUSY;
            end
            W_BUSY: if (!write_done) state <= W_WAIT;
            W_WAIT: begin
               if (write_done) begin
`ifdef HACK_SDRAM_BOOT_CLEAR_EN
                  if (clearing) begin
                     clr_cnt <= clr_cnt + 1'b1;
                     state   <= CLEAR;
                  end else begin
                     state <= IDLE;
                  end
`else
                  state <= IDLE;
`endif
               end
            end
            R_GO: begin
               read_go <= 1'b1;
               state   <= R_BUSY;
            end
            R_BUSY: if (!read_done) state <= R_WAIT;
            R_WAIT: if (read_data_available) state <= R_POP;
            R_POP: begin
               read_buffer <= 1'b1;
               rd_data     <= read_buffer_data;
               rd_valid    <= 1'b1;
               state       <= R_DONE;
            end
            R_DONE: if (read_done) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule
